mips_inst_encoder: RTL
======================

# mips_inst_encoder

Sequential instruction encoder and program loader for the pipeline CPU. Accepts symbolic instruction requests through a valid/ready handshake, packs them into 32-bit MIPS words for the supported ISA subset, and writes them sequentially into instruction memory. It is the inverse of the control decoder: every word it emits must decode back to the requested operation.

## Interface
- ADDR_W, 8, word-address width of instruction memory; capacity 2^ADDR_W words
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: clear counter and errors, begin a load session
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept a request this cycle
- req_cls  in  5  instruction class (see Operation)
- req_rs, req_rt, req_rd  in  5 each  register fields
- req_imm  in  16  I-type immediate, passed through unmodified
- req_tgt  in  26  J-type target field
- req_last  in  1  marks final instruction of the session
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word write address
- imem_wdata  out  32  encoded word
- busy  out  1  session in progress (LOAD or WRITE)
- done  out  1  session ended (DONE or FULL)
- err_illegal  out  1  sticky: an unsupported req_cls was accepted
- err_full  out  1  sticky: memory filled before req_last
- word_count  out  ADDR_W+1  words written this session

## Operation
- Classes (opcode/funct hex): 0 ADD 00/20, 1 SUB 00/22, 2 AND 00/24, 3 OR 00/25, 4 XOR 00/26, 5 NOR 00/27, 6 SLT 00/2A, 7 ADDI 08, 8 ANDI 0C, 9 ORI 0D, 10 XORI 0E, 11 SLTI 0A, 12 LW 23, 13 SW 2B, 14 BEQ 04, 15 BNE 05, 16 J 02; 17–31 illegal.
- R-type: {6'h00, rs, rt, rd, 5'h00, funct}. I-type (7–15): {op, rs, rt, imm}. J: {op, tgt}. Unused fields ignored.
- FSM states IDLE, LOAD, WRITE, DONE, FULL.
- IDLE: req_ready=0; start → LOAD.
- LOAD: req_ready=1. Handshake when req_valid && req_ready. Legal class: encoded word and req_last latched, → WRITE. Illegal class: no write, err_illegal set, counter unchanged; if req_last → DONE, else stay LOAD.
- WRITE: imem_we=1 for exactly one cycle with imem_addr = current address, imem_wdata = latched word; address and word_count increment at cycle end. Next: latched last → DONE; else address wraps to 0 (word_count = 2^ADDR_W) → FULL with err_full=1; else → LOAD.
- DONE/FULL: done=1, req_ready=0, all requests ignored; hold until start.
- start in any state (including mid-session) → LOAD next cycle; address, word_count, err_illegal, err_full cleared; a pending WRITE is abandoned (no strobe).
- Last-word precedence: req_last on the word that fills memory → DONE, err_full stays 0.
- busy = state is LOAD or WRITE.

## Timing
- Reset values: state IDLE; req_ready, imem_we, busy, done, err_illegal, err_full = 0; imem_addr, imem_wdata, word_count = 0.
- Handshake in cycle N → imem_we high in N+1; req_ready low in N+1; earliest next accept N+2. Throughput one word per 2 cycles.
- imem_addr, imem_wdata, imem_we registered; imem_wdata stable whenever imem_we=1.
- req_ready is a function of registered state only (no combinational path from req_valid).
- Asynchronous rst mid-write drops the strobe immediately; no partial word.

## Test plan
- start; ADD rs=1 rt=2 rd=3 → imem_we one cycle later, addr 0, wdata 0x00221820; word_count=1.
- Stream LW rs=4 rt=5 imm=0x0010, BEQ rs=1 rt=2 imm=0xFFFF, J tgt=0x0000100 (last) → words 0x8C850010, 0x1022FFFF, 0x08000100 at addrs 0,1,2; done=1, word_count=3.
- All 17 legal classes with random fields, each word fed to the control decoder → decoded op/ALU code/control signals match request class.
- req_cls=20 between two legal requests → err_illegal=1, no strobe, legal words land at consecutive addrs 0,1.
- ADDR_W=2, 5 requests without last → 4 writes (addrs 0–3), FULL, err_full=1, 5th request not accepted; repeat with last on 4th → DONE, err_full=0.
- Assert rst during WRITE, then start mid-session → outputs return to reset values; new session restarts at addr 0 with errors cleared.

Source files
------------

// File: rtl/mips_inst_encoder_if.sv
// Request handshake and instruction-memory write bus of the MIPS instruction encoder.
interface mips_inst_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_cls;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [15:0]       req_imm;
    logic [25:0]       req_tgt;
    logic              req_last;

    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Program source side: issues requests, observes the memory writes.
    modport master (
        output req_valid, req_cls, req_rs, req_rt, req_rd, req_imm, req_tgt, req_last,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    // Encoder side.
    modport slave (
        input  req_valid, req_cls, req_rs, req_rt, req_rd, req_imm, req_tgt, req_last,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/mips_inst_encoder.sv
// Sequential MIPS instruction encoder / program loader: packs symbolic requests into 32-bit
// words and writes them to consecutive instruction-memory addresses, one word per 2 cycles.
module mips_inst_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    mips_inst_encoder_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               err_illegal,
    output logic               err_full,
    output logic [ADDR_W:0]    word_count
);
    typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone, StFull} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              err_ill_q, err_ill_d;
    logic              err_full_q, err_full_d;
    logic              we_q, we_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic [31:0]       r_base;
    logic [25:0]       i_fields;

    // Pack the request fields into a MIPS word; classes 17..31 are flagged illegal
    always_comb begin
        r_base    = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'h00, 6'h00};
        i_fields  = {bus.req_rs, bus.req_rt, bus.req_imm};
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (bus.req_cls)
            5'd0:    enc_word = r_base | 32'h20;           // ADD
            5'd1:    enc_word = r_base | 32'h22;           // SUB
            5'd2:    enc_word = r_base | 32'h24;           // AND
            5'd3:    enc_word = r_base | 32'h25;           // OR
            5'd4:    enc_word = r_base | 32'h26;           // XOR
            5'd5:    enc_word = r_base | 32'h27;           // NOR
            5'd6:    enc_word = r_base | 32'h2A;           // SLT
            5'd7:    enc_word = {6'h08, i_fields};         // ADDI
            5'd8:    enc_word = {6'h0C, i_fields};         // ANDI
            5'd9:    enc_word = {6'h0D, i_fields};         // ORI
            5'd10:   enc_word = {6'h0E, i_fields};         // XORI
            5'd11:   enc_word = {6'h0A, i_fields};         // SLTI
            5'd12:   enc_word = {6'h23, i_fields};         // LW
            5'd13:   enc_word = {6'h2B, i_fields};         // SW
            5'd14:   enc_word = {6'h04, i_fields};         // BEQ
            5'd15:   enc_word = {6'h05, i_fields};         // BNE
            5'd16:   enc_word = {6'h02, bus.req_tgt};      // J
            default: enc_legal = 1'b0;
        endcase
    end

    // Session FSM and address/count bookkeeping; start overrides everything, including a
    // handshake in the same cycle
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        word_d     = word_q;
        last_d     = last_q;
        err_ill_d  = err_ill_q;
        err_full_d = err_full_q;
        if (start) begin
            state_d    = StLoad;
            addr_d     = '0;
            count_d    = '0;
            last_d     = 1'b0;
            err_ill_d  = 1'b0;
            err_full_d = 1'b0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (bus.req_valid) begin
                        if (enc_legal) begin
                            word_d  = enc_word;
                            last_d  = bus.req_last;
                            state_d = StWrite;
                        end else begin
                            err_ill_d = 1'b1;
                            if (bus.req_last) begin
                                state_d = StDone;
                            end
                        end
                    end
                end
                StWrite: begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W + 1)'(1);
                    // A final word that also fills memory ends the session cleanly
                    if (last_q) begin
                        state_d = StDone;
                    end else if (addr_q == {ADDR_W{1'b1}}) begin
                        state_d    = StFull;
                        err_full_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
                default: ;
            endcase
        end
        // Strobe is a flop so it is glitch-free and aligned with the registered address/data
        we_d = (state_d == StWrite);
    end

    // State and datapath registers; async reset returns everything to idle at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            count_q    <= '0;
            word_q     <= 32'h0;
            last_q     <= 1'b0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            word_q     <= word_d;
            last_q     <= last_d;
            err_ill_q  <= err_ill_d;
            err_full_q <= err_full_d;
            we_q       <= we_d;
        end
    end

    assign bus.req_ready  = (state_q == StLoad);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = word_q;
    assign busy           = (state_q == StLoad) || (state_q == StWrite);
    assign done           = (state_q == StDone) || (state_q == StFull);
    assign err_illegal    = err_ill_q;
    assign err_full       = err_full_q;
    assign word_count     = count_q;
endmodule
